demux_src: RTL and testbench

Clocked four-phase source that launches single-word transfers into the asynchronous two-way demux. It accepts words and a destination-select bit from a synchronous valid/ready stream. For each word it drives the demux request, data and one-hot steering controls (ctl_a / ctl_b). It closes the handshake by synchronizing the demux's combined acknowledge. A one-entry prefetch register lets the next word be accepted while the current async handshake is in flight.

---
 rtl/demux_src.sv | 240 ++++++++++++++++++++++++
 tb/tb_demux_src.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_src.sv
`default_nettype none
// ============================================================================
// Module      : demux_src
// Description : Clocked four-phase source for an asynchronous two-way demux.
//               Words and a destination-select bit arrive on a valid/ready
//               stream and land in a one-entry prefetch register. Each word is
//               then launched as a four-phase transfer: data and one-hot
//               steering (ctl_a_o / ctl_b_o) are set up one cycle before the
//               request rises. The handshake is closed by synchronising the
//               demux's combined acknowledge.
//
//               Optional feature macro: DEMUX_SRC_TIMEOUT_EN
//                 defined   -> ack-wait counter and sticky err flag
//                 undefined -> err tied to 0, no counter built
//
// Parameters  : N           data width
//               SYNC_STAGES ack synchroniser depth (>= 2)
//               TIMEOUT     ack-wait limit in cycles (timeout build only)
//
// Ports       : clk, rst           clock, async active-high reset
//               in_valid/in_ready  upstream handshake (ready = prefetch empty)
//               in_data, in_sel    word and route (0 -> ctl_a, 1 -> ctl_b)
//               r_o, a_i           four-phase request / async acknowledge
//               d_o                data to demux
//               ctl_a_o, ctl_b_o   one-hot steering to demux
//               busy               handshake in flight or prefetch full
//               err                sticky ack timeout
//
// Revision    : 1.0  initial release
// ============================================================================
module demux_src #(
    parameter int N           = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sel,
    output logic         r_o,
    input  logic         a_i,
    output logic [N-1:0] d_o,
    output logic         ctl_a_o,
    output logic         ctl_b_o,
    output logic         busy,
    output logic         err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SETUP   = 2'd1;
    localparam logic [1:0] c_REQ     = 2'd2;
    localparam logic [1:0] c_RELEASE = 2'd3;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("demux_src: SYNC_STAGES must be at least 2");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("demux_src: TIMEOUT must be at least 1");
        end
    endgenerate

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   r_live;
    logic [N-1:0]           r_pend_data;
    logic                   r_pend_sel;
    logic                   r_pend_full;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req;
    logic                   r_ctl_a;
    logic                   r_ctl_b;
    logic [N-1:0]           r_d;

    logic                   w_ack_s;
    logic                   w_accept;
    logic                   w_launch;
    logic                   w_req_nxt;
    logic                   w_ctl_a_nxt;
    logic                   w_ctl_b_nxt;
    logic [N-1:0]           w_d_nxt;

    assign w_ack_s  = r_sync[SYNC_STAGES-1];
    // r_live keeps in_ready low while reset is held and until the first edge
    // after release; in_ready depends only on registers.
    assign in_ready = r_live & ~r_pend_full;
    assign w_accept = in_valid & in_ready;
    // A launch also requires the synchronised ack to be low, so a stale ack
    // left over from a reset mid-handshake is drained before the next word.
    assign w_launch = r_pend_full & ~w_ack_s &
                      ((r_state == c_IDLE) | (r_state == c_RELEASE));

    // ------------------------------------------------------------------
    // Ack synchroniser, prefetch register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= '0;
            r_live      <= 1'b0;
            r_pend_data <= '0;
            r_pend_sel  <= 1'b0;
            r_pend_full <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], a_i};
            r_live <= 1'b1;
            // An accept and a launch on the same edge: the launched word is the
            // old content, the new word takes its place.
            if (w_accept) begin
                r_pend_data <= in_data;
                r_pend_sel  <= in_sel;
                r_pend_full <= 1'b1;
            end else if (w_launch) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_req   <= 1'b0;
            r_ctl_a <= 1'b0;
            r_ctl_b <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_ctl_a <= w_ctl_a_nxt;
            r_ctl_b <= w_ctl_b_nxt;
            r_d     <= w_d_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = c_SETUP;
                end
            end
            c_SETUP: begin
                w_state_nxt = c_REQ;
            end
            c_REQ: begin
                if (w_ack_s) begin
                    w_state_nxt = c_RELEASE;
                end
            end
            c_RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = r_pend_full ? c_SETUP : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next values of the registered demux-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_req_nxt   = r_req;
        w_ctl_a_nxt = r_ctl_a;
        w_ctl_b_nxt = r_ctl_b;
        w_d_nxt     = r_d;
        if (w_launch) begin
            w_d_nxt     = r_pend_data;
            w_ctl_a_nxt = ~r_pend_sel;
            w_ctl_b_nxt = r_pend_sel;
        end
        if (r_state == c_SETUP) begin
            w_req_nxt = 1'b1;
        end
        // Request and steering drop together so both C-element inputs of the
        // selected demux branch fall on the same edge.
        if ((r_state == c_REQ) && w_ack_s) begin
            w_req_nxt   = 1'b0;
            w_ctl_a_nxt = 1'b0;
            w_ctl_b_nxt = 1'b0;
        end
    end

    assign r_o     = r_req;
    assign ctl_a_o = r_ctl_a;
    assign ctl_b_o = r_ctl_b;
    assign d_o     = r_d;
    assign busy    = (r_state != c_IDLE) | r_pend_full;

    // ------------------------------------------------------------------
    // Optional ack-wait timeout
    // ------------------------------------------------------------------
`ifdef DEMUX_SRC_TIMEOUT_EN
    localparam int c_CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int c_CNT_W   = (c_CNT_RAW < 8)  ? 8  :
                               (c_CNT_RAW > 32) ? 32 : c_CNT_RAW;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic               w_waiting;
    logic               w_cnt_clr;

    assign w_waiting = (r_state == c_REQ) | (r_state == c_RELEASE);
    assign w_cnt_clr = (w_state_nxt != r_state) &&
                       ((w_state_nxt == c_REQ) || (w_state_nxt == c_RELEASE));

    // The counter saturates at the limit; err is raised on the edge where the
    // count reaches it and the handshake itself is left untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_waiting && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == (c_LIMIT - 1'b1)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_src.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_src
// Description : Directed bench for demux_src. Accepted words are pushed to a
//               scoreboard and popped when the request rises; a small demux
//               model returns the acknowledge after a programmable delay.
// Revision    : 1.0  initial release
// ============================================================================
module tb_demux_src;

    localparam int N  = 8;
    localparam int S  = 2;
    localparam int TO = 10;
    // Per word: SETUP (1) + REQ until ack seen (S+1) + RELEASE until ack low (S+1)
    localparam int PERIOD = 2 * S + 3;
`ifdef DEMUX_SRC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_sel;
    logic         r_o;
    logic         a_i;
    logic [N-1:0] d_o;
    logic         ctl_a_o;
    logic         ctl_b_o;
    logic         busy;
    logic         err;

    logic         a_man  = 1'b0;
    logic         a_auto = 1'b0;
    bit           auto_ack = 1'b0;
    int           ack_dly = 0;
    int           ack_cnt = 0;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           last_rise = -1;
    bit           per_chk = 1'b0;
    logic         r_prev = 1'b0;
    logic [N:0]   exp_q[$];
    logic [N:0]   e;

    assign a_i = auto_ack ? a_auto : a_man;

    always #5 clk = ~clk;

    demux_src #(
        .N          (N),
        .SYNC_STAGES(S),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_sel  (in_sel),
        .r_o     (r_o),
        .a_i     (a_i),
        .d_o     (d_o),
        .ctl_a_o (ctl_a_o),
        .ctl_b_o (ctl_b_o),
        .busy    (busy),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; in_valid stays high on return.
    task automatic send(input logic [N-1:0] d, input logic s, input int max_wait);
        bit got;
        int w;
        got = 1'b0;
        w   = 0;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        while (!got && w < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            w++;
        end
        #1;
        if (got) exp_q.push_back({s, d});
        chk("accept_wait", 32'(got && (w <= max_wait)), 32'd1);
    endtask

    always @(posedge clk) cyc++;

    // Demux acknowledge model: follows r_o after ack_dly extra cycles.
    always @(posedge clk) begin
        #2;
        if (auto_ack) begin
            if (r_o !== a_auto) begin
                if (ack_cnt >= ack_dly) begin
                    a_auto  = r_o;
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // Output monitor: one-hot steering and scoreboard pop on request rise.
    always @(negedge clk) begin
        chk("ctl_exclusive", 32'(ctl_a_o & ctl_b_o), 32'd0);
        if (!rst && r_o && !r_prev) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("launch_d_o", 32'(d_o), 32'(e[N-1:0]));
                chk("launch_ctl_a", 32'(ctl_a_o), 32'(!e[N]));
                chk("launch_ctl_b", 32'(ctl_b_o), 32'(e[N]));
            end
            if (per_chk && last_rise >= 0) chk("req_period", 32'(cyc - last_rise), 32'(PERIOD));
            last_rise = cyc;
        end
        r_prev = r_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_r_o", 32'(r_o), 32'd0);
        chk("rst_ctl_a", 32'(ctl_a_o), 32'd0);
        chk("rst_ctl_b", 32'(ctl_b_o), 32'd0);
        chk("rst_d_o", 32'(d_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick(); tick();
        rst = 1'b0;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        // ---- single word 0xA5 to output 0, manual ack ----
        in_data = 8'hA5; in_sel = 1'b0; in_valid = 1'b1;
        tick();                                   // edge k: accept
        exp_q.push_back({1'b0, 8'hA5});
        in_valid = 1'b0;
        chk("t1_in_ready_full", 32'(in_ready), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_r_o_k", 32'(r_o), 32'd0);
        tick();                                   // k+1: SETUP
        chk("t1_ctl_a", 32'(ctl_a_o), 32'd1);
        chk("t1_ctl_b", 32'(ctl_b_o), 32'd0);
        chk("t1_d_o", 32'(d_o), 32'hA5);
        chk("t1_r_o_setup", 32'(r_o), 32'd0);
        chk("t1_in_ready_free", 32'(in_ready), 32'd1);
        tick();                                   // k+2: REQ
        chk("t1_r_o_rise", 32'(r_o), 32'd1);
        tick(); tick();                           // k+4
        a_man = 1'b1;                             // first edge after: k+5
        tick();
        chk("t1_r_o_hold1", 32'(r_o), 32'd1);
        tick();
        chk("t1_r_o_hold2", 32'(r_o), 32'd1);
        tick();                                   // k+7
        chk("t1_r_o_fall", 32'(r_o), 32'd0);
        chk("t1_ctl_a_fall", 32'(ctl_a_o), 32'd0);
        chk("t1_d_o_hold", 32'(d_o), 32'hA5);
        a_man = 1'b0;                             // first edge after: k+8
        tick();
        chk("t1_busy_rel1", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_rel2", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_drop", 32'(busy), 32'd0);

        // ---- alternating routes, valid held high, delayed ack ----
        auto_ack = 1'b1; ack_dly = 3;
        send(8'h11, 1'b0, 20);
        send(8'h22, 1'b1, 20);
        send(8'h33, 1'b0, 20);
        send(8'h44, 1'b1, 20);
        in_valid = 1'b0;
        for (int t = 0; t < 100 && busy; t++) tick();
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);

        // ---- zero-delay ack, 8 streamed words, request period ----
        ack_dly = 0; per_chk = 1'b1; last_rise = -1;
        for (int i = 0; i < 8; i++) send(8'(8'h80 + i), i[0], 2 * PERIOD);
        in_valid = 1'b0;
        for (int t = 0; t < 100 && busy; t++) tick();
        per_chk = 1'b0;
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_sb_drained", 32'(exp_q.size()), 32'd0);

        // ---- reset in REQ with ack high, stale ack drained ----
        auto_ack = 1'b0; a_man = 1'b0;
        send(8'h3C, 1'b1, 5);
        in_valid = 1'b0;
        for (int t = 0; t < 20 && r_o !== 1'b1; t++) tick();
        chk("t4_req", 32'(r_o), 32'd1);
        a_man = 1'b1;
        tick();
        chk("t4_still_req", 32'(r_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_r_o", 32'(r_o), 32'd0);
        chk("t4_rst_ctl_a", 32'(ctl_a_o), 32'd0);
        chk("t4_rst_ctl_b", 32'(ctl_b_o), 32'd0);
        chk("t4_rst_d_o", 32'(d_o), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        rst = 1'b0;
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        send(8'h5A, 1'b0, 5);
        in_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("t4_blocked_ctl", 32'(ctl_a_o), 32'd0);
            chk("t4_blocked_r_o", 32'(r_o), 32'd0);
        end
        a_man = 1'b0;                             // first edge after: j
        tick();
        chk("t4_j_ctl", 32'(ctl_a_o), 32'd0);
        tick();
        chk("t4_j1_ctl", 32'(ctl_a_o), 32'd0);
        tick();
        chk("t4_launch_ctl", 32'(ctl_a_o), 32'd1);
        chk("t4_launch_d_o", 32'(d_o), 32'h5A);
        auto_ack = 1'b1; ack_dly = 1;
        for (int t = 0; t < 100 && busy; t++) tick();
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);

        // ---- ack withheld: timeout flag behaviour ----
        auto_ack = 1'b0; a_man = 1'b0;
        send(8'hC3, 1'b1, 5);
        in_valid = 1'b0;
        for (int t = 0; t < 20 && r_o !== 1'b1; t++) tick();
        chk("t5_req", 32'(r_o), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("t5_err", 32'(err), 32'(TO_EN && (i >= TO)));
            chk("t5_r_o_hold", 32'(r_o), 32'd1);
        end
        a_man = 1'b1;
        for (int t = 0; t < 20 && r_o !== 1'b0; t++) tick();
        chk("t5_late_ack_r_o", 32'(r_o), 32'd0);
        chk("t5_late_ack_ctl_b", 32'(ctl_b_o), 32'd0);
        a_man = 1'b0;
        for (int t = 0; t < 20 && busy; t++) tick();
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_err_final", 32'(err), 32'(TO_EN));
        chk("t5_d_o", 32'(d_o), 32'hC3);
        chk("t5_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
